// File: rtl/csc_sync_ctrl.sv
// CFEB fiber synchronisation sequencer: waits for stable links, settles, reports
// per-fiber sync-done, and issues bounded automatic resyncs on lost sync.
module csc_sync_ctrl #(
  parameter int MXCFEB       = 7,
  parameter int LINK_STABLE  = 64,
  parameter int LINK_TIMEOUT = 4096,
  parameter int CNTW         = 13
) (
  input  logic              clock,
  input  logic              global_reset_n,
  input  logic              ttc_resync,
  input  logic [MXCFEB-1:0] link_good,
  input  logic [MXCFEB-1:0] cfeb_fiber_enable,
  input  logic              cfebs_lostsync,
  input  logic              cfebs_me1a_lostsync,
  input  logic [7:0]        settle_dly,
  input  logic [3:0]        max_retry,
  output logic [MXCFEB-1:0] cfeb_sync_done,
  output logic              sync_req,
  output logic [3:0]        retry_cnt,
  output logic              sync_fail,
  output logic [2:0]        sync_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LINK = 3'd1,
    SETTLE    = 3'd2,
    DONE      = 3'd3,
    RECOVER   = 3'd4,
    FAIL      = 3'd5
  } state_e;

  localparam logic [CNTW-1:0] STABLE_LAST  = CNTW'(LINK_STABLE - 1);
  localparam logic [CNTW-1:0] TIMEOUT_LAST = CNTW'(LINK_TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_ONE      = CNTW'(1);

  state_e            state_q, state_d;
  logic              rel_q;
  logic [CNTW-1:0]   stable_q, stable_d;
  logic [CNTW-1:0]   tmo_q, tmo_d;
  logic [7:0]        settle_q, settle_d;
  logic [3:0]        retry_q, retry_d;
  logic              fail_q, fail_d;
  logic              req_q, req_d;
  logic [MXCFEB-1:0] done_q, done_d;
  logic              all_good;
  logic              lost;

  // Disabled fibers count as good so they can never hold off the sequence.
  assign all_good = &(link_good | ~cfeb_fiber_enable);
  assign lost     = cfebs_lostsync | cfebs_me1a_lostsync;

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    tmo_d    = tmo_q;
    settle_d = settle_q;
    retry_d  = retry_q;
    fail_d   = fail_q;
    req_d    = 1'b0;

    // rel_q is the first release-synchroniser flop; the IDLE state register is the second.
    if (!rel_q) begin
      state_d = IDLE;
    end else if (ttc_resync) begin
      state_d  = WAIT_LINK;
      stable_d = '0;
      tmo_d    = '0;
      settle_d = '0;
      retry_d  = '0;
      fail_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = WAIT_LINK;
          stable_d = '0;
          tmo_d    = '0;
        end
        WAIT_LINK: begin
          tmo_d    = tmo_q + CNT_ONE;
          stable_d = all_good ? stable_q + CNT_ONE : '0;
          if (all_good && stable_q == STABLE_LAST) begin
            state_d  = SETTLE;
            settle_d = settle_dly;
          end else if (tmo_q == TIMEOUT_LAST) begin
            state_d = RECOVER;
          end
        end
        SETTLE: begin
          if (!all_good) begin
            state_d  = WAIT_LINK;
            stable_d = '0;
            tmo_d    = '0;
          end else if (settle_q <= 8'd1) begin
            state_d = DONE;
          end else begin
            settle_d = settle_q - 8'd1;
          end
        end
        DONE: begin
          // A link drop outranks lost-sync: it is not charged as a retry.
          if (!all_good) begin
            state_d  = WAIT_LINK;
            stable_d = '0;
            tmo_d    = '0;
          end else if (lost) begin
            state_d = RECOVER;
          end
        end
        RECOVER: begin
          if (retry_q < max_retry) begin
            req_d    = 1'b1;
            retry_d  = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
            state_d  = WAIT_LINK;
            stable_d = '0;
            tmo_d    = '0;
          end else begin
            fail_d  = 1'b1;
            state_d = FAIL;
          end
        end
        FAIL:    state_d = FAIL;
        default: state_d = IDLE;
      endcase
    end

    // Done only while staying in DONE, so it drops on the same edge that leaves DONE.
    done_d = (state_q == DONE && state_d == DONE) ? '1 : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      rel_q    <= 1'b0;
      state_q  <= IDLE;
      stable_q <= '0;
      tmo_q    <= '0;
      settle_q <= '0;
      retry_q  <= '0;
      fail_q   <= 1'b0;
      req_q    <= 1'b0;
      done_q   <= '0;
    end else begin
      rel_q    <= 1'b1;
      state_q  <= state_d;
      stable_q <= stable_d;
      tmo_q    <= tmo_d;
      settle_q <= settle_d;
      retry_q  <= retry_d;
      fail_q   <= fail_d;
      req_q    <= req_d;
      done_q   <= done_d;
    end
  end

  assign cfeb_sync_done = done_q;
  assign sync_req       = req_q;
  assign retry_cnt      = retry_q;
  assign sync_fail      = fail_q;
  assign sync_state     = state_q;

endmodule

// File: doc/csc_sync_ctrl.md
Name: csc_sync_ctrl

Overview:
- Sequences CFEB fiber synchronisation after power-up and TTC resync, and drives the per-fiber cfeb_sync_done vector consumed by the CSC sync monitor.
- Watches the monitor's lost-sync flags (ME1/b group: CFEB0-3; ME1/a group: CFEB4-6) and issues bounded automatic resync requests.
- Enters a sticky fail state when the retry budget is exhausted.

Parameters:
MXCFEB, 7, number of CFEB fibers (group split fixed at 0-3 / 4-6)
LINK_STABLE, 64, consecutive clocks all enabled links must be good before settling
LINK_TIMEOUT, 4096, clocks allowed in WAIT_LINK before a timeout retry
CNTW, 13, width of internal link/timeout counter (must hold LINK_TIMEOUT)

Ports:
clock  in  1  40 MHz LHC clock; all logic on rising edge
global_reset_n  in  1  asynchronous, active-low reset
ttc_resync  in  1  TTC resync pulse; restarts the sequence
link_good  in  MXCFEB  per-fiber link-good status
cfeb_fiber_enable  in  MXCFEB  per-fiber enable
cfebs_lostsync  in  1  sticky lost-sync from monitor, CFEB0-3
cfebs_me1a_lostsync  in  1  sticky lost-sync from monitor, CFEB4-6
settle_dly  in  8  clocks to wait after links are stable before declaring done (0 means 1 clock)
max_retry  in  4  automatic retries allowed; 0 means fail on first loss
cfeb_sync_done  out  MXCFEB  per-fiber sync-done to the monitor
sync_req  out  1  one-clock pulse requesting a CFEB resync
retry_cnt  out  4  retries issued since last reset/ttc_resync
sync_fail  out  1  sticky: retry budget exhausted
sync_state  out  3  current state encoding, for VME readback

Behaviour:
- Reset (global_reset_n=0, asynchronous): state=IDLE, cfeb_sync_done=0, sync_req=0, retry_cnt=0, sync_fail=0, counters=0. Release is synchronised internally with a 2-flop stage, so the first IDLE->WAIT_LINK transition occurs on the 2nd rising edge after deassertion.
- State encoding: IDLE=0, WAIT_LINK=1, SETTLE=2, DONE=3, RECOVER=4, FAIL=5.
- all_good = AND over fibers of (link_good | ~cfeb_fiber_enable). all_good is 1 when no fibers are enabled.
- IDLE: unconditionally -> WAIT_LINK next clock.
- WAIT_LINK:
  - Stable counter increments while all_good and clears when all_good=0.
  - When the counter reaches LINK_STABLE-1 with all_good still high -> SETTLE.
  - A separate timeout counter increments every clock in this state. At LINK_TIMEOUT-1 -> RECOVER, treated as a loss.
- SETTLE: counts settle_dly clocks (value sampled on entry), then -> DONE. If all_good drops -> WAIT_LINK with no retry charged.
- DONE:
  - cfeb_sync_done[i]=1 for every fiber; disabled fibers also report done so they never block the monitor. Outputs are registered, so done is asserted on the clock after entering DONE.
  - all_good drop -> WAIT_LINK; done cleared next clock; no retry charged.
  - cfebs_lostsync | cfebs_me1a_lostsync -> RECOVER.
- RECOVER:
  - One-clock state. Clears cfeb_sync_done.
  - If retry_cnt < max_retry: pulse sync_req for exactly one clock, increment retry_cnt, -> WAIT_LINK.
  - Otherwise: set sync_fail, -> FAIL, with no sync_req.
- FAIL: cfeb_sync_done=0, sync_fail=1. Leaves only on ttc_resync or reset.
- ttc_resync (any state, highest priority after reset): -> WAIT_LINK next clock. Clears cfeb_sync_done, retry_cnt, sync_fail and counters; sync_req is forced 0. A resync arriving in RECOVER suppresses that cycle's sync_req.
- Lost-sync and link drop in the same clock in DONE: link drop wins (-> WAIT_LINK, no retry).
- retry_cnt saturates at 15 and never wraps.
- cfeb_sync_done is zero in every state other than DONE.

Test Plan:
- Reset release, all 7 fibers enabled with link_good=7'h7F, settle_dly=10: cfeb_sync_done goes 0 -> 7'h7F exactly LINK_STABLE+11+2 clocks after release; sync_req stays 0.
- Only fibers 0-3 enabled, link_good=7'h0F: reaches DONE and cfeb_sync_done=7'h7F; toggling link_good[5] has no effect.
- In DONE, pulse cfebs_lostsync with max_retry=2: one sync_req pulse, retry_cnt=1, done drops next clock then re-asserts after re-stabilisation. A second loss gives retry_cnt=2; a third loss gives sync_fail=1, sync_state=5 and no sync_req.
- link_good[2] held low with fiber 2 enabled: after LINK_TIMEOUT clocks, sync_req pulses and retry_cnt=1. Repeat until fail with max_retry=0: immediate FAIL, no sync_req.
- In FAIL, assert ttc_resync: state=WAIT_LINK next clock, retry_cnt=0, sync_fail=0, and DONE is reached again with good links.
- Same clock in DONE with link_good[1] falling and cfebs_me1a_lostsync=1: state -> WAIT_LINK, retry_cnt unchanged, no sync_req. Assert global_reset_n low mid-SETTLE: all outputs 0 immediately, with no clock edge needed.
